// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_sequencer
//  Brief    : Instruction-fetch controller. Owns the PC, issues the imem
//             request handshake, arbitrates redirect/stall/sequential next-PC
//             and buffers one instruction in a skid register while stalled.
//             Optional build macro: PC_MISALIGN_TRAP_EN (misaligned redirect
//             targets are replaced by TRAP_VECTOR and misalign_trap pulses).
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_4,
    output logic        flush,
    output logic        misalign_trap
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_flush;
    logic        r_trap;

    logic        w_misalign;
    logic [31:0] w_target;

`ifdef PC_MISALIGN_TRAP_EN
    assign w_misalign = |redirect_target[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    // Low address bits are always cleared; a misaligned target either traps
    // or is silently word-aligned depending on the build.
    assign w_target = w_misalign ? TRAP_VECTOR : (redirect_target & ~32'h0000_0003);

    // Request and address come only from registered state.
    assign imem_req      = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imem_addr     = r_pc;
    assign if_valid      = r_if_valid;
    assign if_instr      = r_if_instr;
    assign if_pc         = r_if_pc;
    assign if_pc_4       = r_if_pc + 32'd4;
    assign flush         = r_flush;
    assign misalign_trap = r_trap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_VECTOR;
            r_tgt        <= RESET_VECTOR;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'd0;
            r_if_pc      <= 32'd0;
            r_flush      <= 1'b0;
            r_trap       <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            r_trap  <= 1'b0;
            if (redirect_valid) begin
                r_flush    <= 1'b1;
                r_trap     <= w_misalign;
                r_if_valid <= 1'b0;
            end
            case (r_state)
                S_BOOT: begin
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (redirect_valid) begin
                        // An un-acked request must complete at its old address.
                        if (imem_ack) begin
                            r_pc <= w_target;
                        end else begin
                            r_tgt   <= w_target;
                            r_state <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_pc <= r_pc + 32'd4;
                        if (stall) begin
                            r_hold_instr <= imem_rdata;
                            r_hold_pc    <= r_pc;
                            r_state      <= S_HOLD;
                        end else begin
                            r_if_instr <= imem_rdata;
                            r_if_pc    <= r_pc;
                            r_if_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end else if (!stall) begin
                        r_if_instr <= r_hold_instr;
                        r_if_pc    <= r_hold_pc;
                        r_if_valid <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        r_pc    <= redirect_valid ? w_target : r_tgt;
                        r_state <= S_FETCH;
                    end else if (redirect_valid) begin
                        r_tgt <= w_target;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_sequencer
//  Brief    : Directed bench for pc_fetch_sequencer with hand-computed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    localparam logic [31:0] C_TRAP = 32'h0000_0300;
    localparam logic [31:0] C_SALT = 32'hDEAD_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_4;
    logic        flush;
    logic        misalign_trap;

    int n_vec;
    int n_err;

    pc_fetch_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (C_TRAP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_4         (if_pc_4),
        .flush           (flush),
        .misalign_trap   (misalign_trap)
    );

    // Memory model: each word's content is its address salted with a constant.
    assign imem_rdata = imem_addr ^ C_SALT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        imem_ack = 1'b0;

        tick();
        tick();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc",    if_pc, 32'h0);
        chk("rst_pc4",   if_pc_4, 32'h4);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_trap",  {31'd0, misalign_trap}, 32'd0);

        // Sequential fetch with zero-wait memory
        rst = 1'b0;
        imem_ack = 1'b1;
        tick();
        chk("boot_req",   {31'd0, imem_req}, 32'd1);
        chk("boot_addr",  imem_addr, 32'h0);
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("seq_addr4",  imem_addr, 32'h4);
        chk("seq_pc0",    if_pc, 32'h0);
        chk("seq_pc4_0",  if_pc_4, 32'h4);
        chk("seq_instr0", if_instr, 32'hDEAD_0000);
        chk("seq_valid0", {31'd0, if_valid}, 32'd1);
        tick();
        chk("seq_addr8",  imem_addr, 32'h8);
        chk("seq_pc4",    if_pc, 32'h4);
        chk("seq_pc4_4",  if_pc_4, 32'h8);
        tick();
        chk("seq_addrC",  imem_addr, 32'hC);
        chk("seq_pc8",    if_pc, 32'h8);

        // Three stall cycles, one word lands in the skid buffer
        stall = 1'b1;
        tick();
        chk("hold1_req",   {31'd0, imem_req}, 32'd0);
        chk("hold1_pc",    if_pc, 32'h8);
        chk("hold1_valid", {31'd0, if_valid}, 32'd1);
        chk("hold1_addr",  imem_addr, 32'h10);
        tick();
        chk("hold2_req",   {31'd0, imem_req}, 32'd0);
        chk("hold2_pc",    if_pc, 32'h8);
        tick();
        chk("hold3_req",   {31'd0, imem_req}, 32'd0);
        chk("hold3_instr", if_instr, 32'hDEAD_0008);
        stall = 1'b0;
        tick();
        chk("rel_pc",    if_pc, 32'hC);
        chk("rel_instr", if_instr, 32'hDEAD_000C);
        chk("rel_req",   {31'd0, imem_req}, 32'd1);
        chk("rel_addr",  imem_addr, 32'h10);
        tick();
        chk("rel_pc_next", if_pc, 32'h10);
        chk("rel_addr2",   imem_addr, 32'h14);

        // Redirect while the request is pending, ack delayed
        imem_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        chk("drn_flush", {31'd0, flush}, 32'd1);
        chk("drn_addr",  imem_addr, 32'h14);
        chk("drn_req",   {31'd0, imem_req}, 32'd1);
        chk("drn_valid", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk("drn_flush2", {31'd0, flush}, 32'd0);
        chk("drn_addr2",  imem_addr, 32'h14);
        chk("drn_valid2", {31'd0, if_valid}, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("drn_newaddr", imem_addr, 32'h200);
        chk("drn_valid3",  {31'd0, if_valid}, 32'd0);
        tick();
        chk("drn_ifpc",  if_pc, 32'h200);
        chk("drn_instr", if_instr, 32'hDEAD_0200);

        // Stall, redirect and ack together: redirect wins
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0080;
        tick();
        chk("pri_valid", {31'd0, if_valid}, 32'd0);
        chk("pri_flush", {31'd0, flush}, 32'd1);
        chk("pri_addr",  imem_addr, 32'h80);
        stall = 1'b0;
        redirect_valid = 1'b0;
        tick();
        chk("pri_ifpc",   if_pc, 32'h80);
        chk("pri_flush2", {31'd0, flush}, 32'd0);

        // PC wraps at the top of the address space
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        chk("wrap_next",  imem_addr, 32'h0);
        chk("wrap_pc",    if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",   if_pc_4, 32'h0);
        chk("wrap_instr", if_instr, 32'h2152_FFFC);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0102;
        tick();
        chk("mis_flush", {31'd0, flush}, 32'd1);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_addr",  imem_addr, C_TRAP);
        chk("mis_trap",  {31'd0, misalign_trap}, 32'd1);
`else
        chk("mis_addr",  imem_addr, 32'h100);
        chk("mis_trap",  {31'd0, misalign_trap}, 32'd0);
`endif
        redirect_valid = 1'b0;
        tick();
        chk("mis_trap2", {31'd0, misalign_trap}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_ifpc", if_pc, C_TRAP);
`else
        chk("mis_ifpc", if_pc, 32'h100);
`endif

        // Reset during an outstanding request
        imem_ack = 1'b0;
        tick();
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_req",   {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr",  imem_addr, 32'h0);
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_pc4",   if_pc_4, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Instruction-fetch controller that owns the program counter, sequences the PC+4 increment, and drives the instruction-memory request handshake. It sits between the hazard/branch logic and the IF/ID pipeline register. It arbitrates three competing next-PC sources: sequential, redirect, and hold. It also buffers one fetched instruction when the pipeline stalls.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000, first fetch address after reset.
- `TRAP_VECTOR`, default 32'h0000_0100, redirect address for a misaligned target; used only with `PC_MISALIGN_TRAP_EN`.
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit holds IF/ID; outputs must stay frozen.
- `redirect_valid`  in  1  taken branch/jump from EX.
- `redirect_target`  in  32  new PC for the redirect.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address.
- `imem_ack`  in  1  data valid on `imem_rdata` this cycle; ignored when `imem_req`=0.
- `imem_rdata`  in  32  fetched instruction.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a live instruction.
- `if_instr`  out  32  instruction to IF/ID.
- `if_pc`  out  32  PC of `if_instr`.
- `if_pc_4`  out  32  `if_pc`+4, modulo 2^32.
- `flush`  out  1  one-cycle pulse that kills younger instructions after a redirect.
- `misalign_trap`  out  1  one-cycle pulse; tied 0 when `PC_MISALIGN_TRAP_EN` is not compiled in.

## Operation
Internal registers:
- `pc`: next fetch address.
- `tgt`: saved redirect target.
- `hold_instr`, `hold_pc`: skid buffer.

States:
- **BOOT**: `imem_req`=0. Next state is FETCH.
- **FETCH**: `imem_req`=1, `imem_addr`=`pc`.
  - Redirect (any ack): `pc`<=target, `if_valid`<=0, `flush`<=1; any acked data is discarded. Stay in FETCH only if ack or no request is pending; a pending un-acked request goes to DRAIN with `tgt`<=target.
  - Ack, no stall: `if_instr`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1, `pc`<=`pc`+4.
  - Ack with stall: `hold_*`<=fetched data and `pc`; `pc`<=`pc`+4; go to HOLD. IF/ID outputs are unchanged.
  - No ack, no stall: `if_valid`<=0 (bubble).
  - No ack with stall: outputs are unchanged.
- **HOLD**: `imem_req`=0.
  - `stall`=0: outputs <= `hold_*`, `if_valid`<=1, go to FETCH.
  - Redirect: the buffer is dropped, `pc`<=target, `if_valid`<=0, `flush`<=1, go to FETCH.
- **DRAIN**: `imem_req`=1, `imem_addr` is the old `pc`, held stable.
  - Ack: data is discarded, `pc`<=`tgt`, go to FETCH.
  - A further redirect overwrites `tgt`; the latest target wins.

Rules:
- Handshake: once `imem_req` rises with an address, both stay stable until `imem_ack`. A request is never withdrawn or re-addressed mid-flight.
- Priority: redirect > stall > sequential. A redirect that coincides with stall still flushes.
- Arithmetic: all PC adds are 32-bit unsigned with wrap; 32'hFFFF_FFFC+4 = 0.

## Timing
Reset values (while `rst`=1):
- state=BOOT, `pc`=`RESET_VECTOR`.
- `imem_req`=0, `imem_addr`=`RESET_VECTOR`.
- `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_4`=4.
- `flush`=0, `misalign_trap`=0.

Cycle behaviour:
- First clock edge with `rst`=0: BOOT->FETCH. `imem_req` rises the following cycle.
- Latency: an ack in cycle N makes `if_valid`/`if_instr` visible in N+1. With a zero-wait memory, throughput is one instruction per cycle.
- `flush` and `misalign_trap` are registered: they pulse in cycle N+1 for a redirect sampled in cycle N.
- `imem_addr` and `imem_req` are driven from registers/state only; no combinational path from `stall` or `redirect_valid`.
- `rst` mid-request: the transaction is abandoned and all state returns to reset values. Memory must tolerate a dropped request.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_target[1:0]`!=0 loads `TRAP_VECTOR` instead of the target and pulses `misalign_trap` together with `flush`.
  - This applies in every state, including the saved `tgt` for DRAIN.
- Not defined: `redirect_target[1:0]` is forced to 2'b00 and `misalign_trap` is constant 0.

## Test plan
- Reset release, `imem_ack` tied 1 -> `imem_addr` sequence 0,4,8,C; `if_pc` lags by one cycle; `if_pc_4`=`if_pc`+4.
- `stall`=1 for 3 cycles with ack=1 -> `if_*` frozen; exactly one instruction buffered and `imem_req`=0 in HOLD. After release, buffered PC appears next with no gap or duplicate.
- Redirect to 0x200 while a request is pending and ack is delayed 2 cycles -> `imem_addr` holds the old value until ack; next request is 0x200; `flush` pulses once; stale data is never `if_valid`.
- Simultaneous stall, redirect to 0x80, and ack -> redirect wins: `if_valid`=0, `flush`=1, next fetch 0x80.
- `pc`=0xFFFF_FFFC with ack -> next `imem_addr`=0; `if_pc_4`=0.
- With `PC_MISALIGN_TRAP_EN`, redirect to 0x102 -> next fetch is `TRAP_VECTOR` and `misalign_trap` pulses one cycle. Without the macro -> next fetch is 0x100 and `misalign_trap` stays 0.
